// File: rtl/fluxo_dados_rodadas_pkg.sv
// Shared defaults for the memory-sequence game datapath, control unit and top level.
// Also holds the default sequence used when the ROM is built with an init file name.
package fluxo_dados_rodadas_pkg;

    localparam int unsigned DATA_W_DEF  = 4;
    localparam int unsigned ADDR_W_DEF  = 4;
    localparam int unsigned DEPTH_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 5000;

    // Contents of rom.txt, held here so the ROM needs no simulation-only loader.
    function automatic logic [DATA_W_DEF-1:0] sequenciaPadrao(input int unsigned idx);
        logic [DATA_W_DEF-1:0] palavra;
        case (idx)
            0:       palavra = 4'b0001;
            1:       palavra = 4'b0010;
            2:       palavra = 4'b0100;
            3:       palavra = 4'b1000;
            4:       palavra = 4'b0100;
            5:       palavra = 4'b0010;
            6:       palavra = 4'b0001;
            7:       palavra = 4'b0001;
            8:       palavra = 4'b0010;
            9:       palavra = 4'b0010;
            10:      palavra = 4'b0100;
            11:      palavra = 4'b0100;
            12:      palavra = 4'b1000;
            13:      palavra = 4'b1000;
            14:      palavra = 4'b0001;
            15:      palavra = 4'b0100;
            default: palavra = '0;
        endcase
        return palavra;
    endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with clear priority; optional saturation at M-1 instead of wrapping.
module contador_m #(
    parameter int unsigned M      = 16,
    parameter int unsigned N      = 4,
    parameter bit          SATURA = 1'b0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim
);

    localparam logic [N-1:0] QMAX = N'(M - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (zera) begin
            Q <= '0;
        end else if (conta) begin
            if (Q == QMAX) begin
                Q <= SATURA ? QMAX : '0;
            end else begin
                Q <= Q + 1'b1;
            end
        end
    end

    assign fim = (Q == QMAX);

endmodule

// File: rtl/sync_rom_param.sv
// Combinational sequence ROM; addresses at or beyond DEPTH, or an empty MEM_INIT, read as zero.
module sync_rom_param
    import fluxo_dados_rodadas_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter string       MEM_INIT = "rom.txt"
) (
    input  logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] dado
);

    localparam bit CARREGADA = (MEM_INIT != "");

    always_comb begin
        dado = '0;
        if (CARREGADA && (32'(endereco) < DEPTH)) begin
            dado = DATA_W'(sequenciaPadrao(32'(endereco)));
        end
    end

endmodule

// File: rtl/fluxo_dados_rodadas.sv
// Game datapath: address/limit counters, play register, sequence ROM, switch edge detector
// and saturating response timer, all stepped by the control unit.
module fluxo_dados_rodadas
    import fluxo_dados_rodadas_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter string       MEM_INIT = "rom.txt"
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              zeraE,
    input  logic              contaE,
    input  logic              zeraL,
    input  logic              contaL,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic              zeraT,
    input  logic              contaT,
    input  logic [DATA_W-1:0] chaves,
    output logic              igual,
    output logic              enderecoIgualLimite,
    output logic              enderecoMenorLimite,
    output logic              fimE,
    output logic              fimL,
    output logic              jogada_feita,
    output logic              timeout,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [ADDR_W-1:0] db_limite,
    output logic [DATA_W-1:0] db_jogada,
    output logic [DATA_W-1:0] db_memoria
);

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TIMER_W-1:0] unusedContagemTempo;
    logic               chavesPrev;

    contador_m #(.M(DEPTH), .N(ADDR_W), .SATURA(1'b0)) contadorEndereco (
        .clock(clock), .reset_n(reset_n), .zera(zeraE), .conta(contaE),
        .Q(db_contagem), .fim(fimE)
    );

    contador_m #(.M(DEPTH), .N(ADDR_W), .SATURA(1'b0)) contadorLimite (
        .clock(clock), .reset_n(reset_n), .zera(zeraL), .conta(contaL),
        .Q(db_limite), .fim(fimL)
    );

    // Saturating mode keeps fim (the timeout flag) high until zeraT.
    contador_m #(.M(TIMEOUT), .N(TIMER_W), .SATURA(1'b1)) contadorTempo (
        .clock(clock), .reset_n(reset_n), .zera(zeraT), .conta(contaT),
        .Q(unusedContagemTempo), .fim(timeout)
    );

    sync_rom_param #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_INIT(MEM_INIT)) memoria (
        .endereco(db_contagem),
        .dado(db_memoria)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_jogada <= '0;
        end else if (zeraR) begin
            db_jogada <= '0;
        end else if (registraR) begin
            db_jogada <= chaves;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chavesPrev   <= 1'b0;
            jogada_feita <= 1'b0;
        end else begin
            chavesPrev   <= |chaves;
            jogada_feita <= (|chaves) & ~chavesPrev;
        end
    end

    assign igual               = (db_jogada == db_memoria);
    assign enderecoIgualLimite = (db_contagem == db_limite);
    assign enderecoMenorLimite = (db_contagem < db_limite);

endmodule

// File: tb/tb_fluxo_dados_rodadas.sv
// Self-checking bench: directed scenarios plus randomized control traffic, compared every cycle
// against a counter-level model of the datapath.
module tb_fluxo_dados_rodadas;

    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 5000;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic zeraE = 0, contaE = 0, zeraL = 0, contaL = 0;
    logic zeraR = 0, registraR = 0, zeraT = 0, contaT = 0;
    logic [DATA_W-1:0] chaves = '0;
    logic igual, enderecoIgualLimite, enderecoMenorLimite, fimE, fimL, jogada_feita, timeout;
    logic [ADDR_W-1:0] db_contagem, db_limite;
    logic [DATA_W-1:0] db_jogada, db_memoria;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    logic [3:0] romRef [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                                4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};

    int mE, mL, mR, mT;
    bit mPrev, mPulse;

    fluxo_dados_rodadas #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MEM_INIT("rom.txt")
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
        .chaves(chaves),
        .igual(igual), .enderecoIgualLimite(enderecoIgualLimite), .enderecoMenorLimite(enderecoMenorLimite),
        .fimE(fimE), .fimL(fimL), .jogada_feita(jogada_feita), .timeout(timeout),
        .db_contagem(db_contagem), .db_limite(db_limite), .db_jogada(db_jogada), .db_memoria(db_memoria)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    // Reference model: plain integer state updated by the rules of each block.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mE = 0; mL = 0; mR = 0; mT = 0; mPrev = 0; mPulse = 0;
        end else begin
            mPulse = (chaves != 0) && !mPrev;
            mPrev  = (chaves != 0);
            mE = zeraE ? 0 : (contaE ? (mE + 1) % DEPTH : mE);
            mL = zeraL ? 0 : (contaL ? (mL + 1) % DEPTH : mL);
            mR = zeraR ? 0 : (registraR ? int'(chaves) : mR);
            mT = zeraT ? 0 : (contaT ? ((mT < TIMEOUT - 1) ? mT + 1 : mT) : mT);
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            check("m_contagem", 32'(db_contagem), 32'(mE));
            check("m_limite", 32'(db_limite), 32'(mL));
            check("m_jogada", 32'(db_jogada), 32'(mR));
            check("m_memoria", 32'(db_memoria), 32'(romRef[mE]));
            check("m_igual", 32'(igual), 32'(mR == int'(romRef[mE])));
            check("m_endIgual", 32'(enderecoIgualLimite), 32'(mE == mL));
            check("m_endMenor", 32'(enderecoMenorLimite), 32'(mE < mL));
            check("m_fimE", 32'(fimE), 32'(mE == DEPTH - 1));
            check("m_fimL", 32'(fimL), 32'(mL == DEPTH - 1));
            check("m_jogadaFeita", 32'(jogada_feita), 32'(mPulse));
            check("m_timeout", 32'(timeout), 32'(mT == TIMEOUT - 1));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        zeraE = 0; contaE = 0; zeraL = 0; contaL = 0;
        zeraR = 0; registraR = 0; zeraT = 0; contaT = 0;
    endtask

    initial begin
        int pulsos;
        idle();
        reset_n = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1;
        #1;
        check("rst_contagem", 32'(db_contagem), 0);
        check("rst_endIgual", 32'(enderecoIgualLimite), 1);
        check("rst_endMenor", 32'(enderecoMenorLimite), 0);
        check("rst_fim", 32'({fimE, fimL}), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_jogadaFeita", 32'(jogada_feita), 0);
        check("rst_igual", 32'(igual), 0);
        checkEn = 1;

        // Play match
        tick();
        chaves = 4'b0001; registraR = 1; tick(); idle();
        check("match_jogada", 32'(db_jogada), 32'h1);
        check("match_igual", 32'(igual), 1);
        contaE = 1; tick(); idle();
        check("match_contagem", 32'(db_contagem), 1);
        check("match_memoria", 32'(db_memoria), 32'h2);
        check("match_igual0", 32'(igual), 0);

        // Edge detector
        chaves = 0; tick(); tick();
        chaves = 4'b0010; pulsos = 0;
        repeat (6) begin tick(); pulsos += int'(jogada_feita); end
        check("edge_pulso1", 32'(pulsos), 1);
        chaves = 0; tick(); tick();
        chaves = 4'b1000; pulsos = 0;
        repeat (4) begin tick(); pulsos += int'(jogada_feita); end
        check("edge_pulso2", 32'(pulsos), 1);
        chaves = 0;

        // Limit compare
        zeraE = 1; zeraL = 1; tick(); idle();
        contaL = 1; tick(); tick(); idle();
        check("lim_limite", 32'(db_limite), 2);
        check("lim_menor0", 32'(enderecoMenorLimite), 1);
        contaE = 1; tick(); idle();
        check("lim_menor1", 32'(enderecoMenorLimite), 1);
        contaE = 1; tick(); idle();
        check("lim_igual2", 32'(enderecoIgualLimite), 1);
        check("lim_menor2", 32'(enderecoMenorLimite), 0);

        // Wrap and priority
        zeraE = 1; tick(); idle();
        contaE = 1; repeat (15) tick(); idle();
        check("wrap_fimE", 32'(fimE), 1);
        check("wrap_15", 32'(db_contagem), 15);
        contaE = 1; tick(); idle();
        check("wrap_zero", 32'(db_contagem), 0);
        check("wrap_fimE0", 32'(fimE), 0);
        contaE = 1; repeat (3) tick();
        zeraE = 1; tick(); idle();
        check("prio_zeraE", 32'(db_contagem), 0);

        // Timeout saturation
        zeraT = 1; tick(); idle();
        contaT = 1; repeat (TIMEOUT - 2) tick();
        check("to_cedo", 32'(timeout), 0);
        tick();
        check("to_ativo", 32'(timeout), 1);
        repeat (10) tick();
        check("to_satura", 32'(timeout), 1);
        zeraT = 1; tick(); idle();
        check("to_zera", 32'(timeout), 0);

        // Asynchronous reset mid-cycle with nonzero state
        chaves = 4'b0110; registraR = 1; contaE = 1; contaL = 1; contaT = 1;
        repeat (3) tick();
        idle();
        @(posedge clock); #2;
        reset_n = 0; #1;
        check("arst_contagem", 32'(db_contagem), 0);
        check("arst_limite", 32'(db_limite), 0);
        check("arst_jogada", 32'(db_jogada), 0);
        check("arst_endIgual", 32'(enderecoIgualLimite), 1);
        check("arst_timeout", 32'(timeout), 0);
        @(negedge clock);
        reset_n = 1;
        chaves = 0;

        // Randomized traffic
        repeat (2000) begin
            zeraE = ($urandom_range(0, 9) == 0);
            contaE = ($urandom_range(0, 1) == 1);
            zeraL = ($urandom_range(0, 9) == 0);
            contaL = ($urandom_range(0, 2) == 0);
            zeraR = ($urandom_range(0, 9) == 0);
            registraR = ($urandom_range(0, 2) == 0);
            zeraT = ($urandom_range(0, 19) == 0);
            contaT = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                chaves = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            tick();
        end
        idle();
        tick();
        checkEn = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
